// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter for the physical register file.
// Collects completed results (physical tag + data) from NUM_FU functional
// units into per-FU FIFOs. Each cycle it grants up to `N non-empty FIFOs
// onto the `N register file write ports, scanning round-robin from rr_ptr.
// The write ports double as the CDB tag broadcast.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   fu_valid   - FU i presents a result
//   fu_tag     - destination physical tag per FU (tag 0 is accepted, never written)
//   fu_data    - result value per FU
//   fu_ready   - FIFO i can accept this cycle (from registered count)
//   write_en   - register file write enable / CDB valid per port
//   write_idx  - register file write tag / CDB tag per port
//   write_data - register file write data per port
//   busy       - any FIFO non-empty
`ifndef N
`define N 2
`endif

module wb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 6,
  parameter int DATA_W     = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_data,
  output logic [NUM_FU-1:0]              fu_ready,
  output logic [`N-1:0]                  write_en,
  output logic [`N-1:0][TAG_W-1:0]       write_idx,
  output logic [`N-1:0][DATA_W-1:0]      write_data,
  output logic                           busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int PW = (`N > 1) ? $clog2(`N) : 1;

  logic [TAG_W-1:0]  tag_mem  [NUM_FU][FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [NUM_FU][FIFO_DEPTH];
  logic [CW-1:0]     count    [NUM_FU];
  logic [AW-1:0]     head     [NUM_FU];
  logic [AW-1:0]     tail     [NUM_FU];
  logic [FW-1:0]     rr_ptr;

  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] nonempty;
  logic [FW-1:0]     fu;
  logic [FW-1:0]     last_fu;

  always_comb begin
    fu_ready = '0;
    push     = '0;
    nonempty = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (count[i] != CW'(FIFO_DEPTH));
      // A tag-0 result completes the handshake but is never stored.
      push[i]     = fu_valid[i] && fu_ready[i] && (fu_tag[i] != '0);
      nonempty[i] = (count[i] != '0);
    end
    busy = |nonempty;
  end

  // Round-robin scan from rr_ptr; the j-th non-empty FIFO found drives port j.
  always_comb begin
    grant      = '0;
    write_en   = '0;
    write_idx  = '0;
    write_data = '0;
    last_fu    = '0;
    fu         = '0;
    begin
      int unsigned nsel;
      nsel = 0;
      for (int unsigned k = 0; k < NUM_FU; k++) begin
        fu = FW'((32'(rr_ptr) + k) % NUM_FU);
        if (nonempty[fu] && nsel < `N) begin
          grant[fu]                = 1'b1;
          write_en[PW'(nsel)]      = 1'b1;
          write_idx[PW'(nsel)]     = tag_mem[fu][head[fu]];
          write_data[PW'(nsel)]    = data_mem[fu][head[fu]];
          last_fu                  = fu;
          nsel++;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        count[i] <= '0;
        head[i]  <= '0;
        tail[i]  <= '0;
      end
    end else begin
      if (|grant)
        rr_ptr <= FW'((32'(last_fu) + 1) % NUM_FU);
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (push[i])
          tail[i] <= tail[i] + AW'(1);
        if (grant[i])
          head[i] <= head[i] + AW'(1);
        case ({push[i], grant[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Payload storage needs no reset: entries are only read while counted.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        tag_mem[i][tail[i]]  <= fu_tag[i];
        data_mem[i][tail[i]] <= fu_data[i];
      end
    end
  end

endmodule
